bounce_motion: RTL and testbench
================================

// Module: bounce_motion
// PURPOSE
//  Parametrised motion engine for the screen-saver sprite: moves one WxH object around an
//  HxV active area, reflects it off the four borders and reports each hit as a sound code
//  plus a digit change. Successor of the fixed 640x480 bouncer: fully synchronous
//  (no derived clocks), clamped reflection, saturating speed control, corner detection and
//  a timed mute. Sits between the button debouncers and the sprite renderer and sound unit.
// PARAMETERS
//  H_RES      640  active width in pixels
//  V_RES      480  active height in pixels
//  OBJ_W      20   object width
//  OBJ_H      23   object height
//  BORDER     0    margin kept free on every side
//  POS_W      10   position width
//  VEL_W      4    signed velocity width
//  VX_INIT    1    initial x velocity (signed)
//  VY_INIT    2    initial y velocity (signed)
//  X_INIT     100  reset x position
//  Y_INIT     100  reset y position
//  DIV_W      32   free-running divider width
//  DELAY_INIT 18   reset divider bit selecting the step period (2^(d+1) clk)
//  DELAY_MIN  10   fastest allowed delay
//  DELAY_MAX  26   slowest allowed delay
//  VEL_BIT    23   divider bit whose rising edge samples inc_vel/dec_vel
//  SOUND_LEN  4    step ticks mute stays low after a hit
// PORTS
//  clk        in   1      system clock
//  clr        in   1      synchronous reset, active high
//  enable     in   1      1 = animate; 0 = freeze position (divider keeps running)
//  inc_vel    in   1      level: speed up
//  dec_vel    in   1      level: slow down
//  x_pos      out  POS_W  object top-left x
//  y_pos      out  POS_W  object top-left y
//  number     out  3      displayed digit, wraps mod 8
//  code_sound out  2      last sound: stop=00 pong=01 ping=10 go=11
//  sound_stb  out  1      one-cycle pulse when code_sound is updated by a hit
//  mute       out  1      1 = silence
// BEHAVIOUR
//  Reset (clr=1 at posedge): x_pos=X_INIT, y_pos=Y_INIT, vx=VX_INIT, vy=VY_INIT, delay=DELAY_INIT,
//   number=0, code_sound=stop, sound_stb=0, mute=1, divider=0, state=S_WAIT; any in-flight step aborts.
//  X_MIN=BORDER, X_MAX=H_RES-OBJ_W-BORDER; Y_MIN=BORDER, Y_MAX=V_RES-OBJ_H-BORDER.
//  Step tick: one-cycle strobe on rising edge of divider[delay], detected against a registered copy;
//   the registered copy is reloaded with the new bit whenever delay changes (no spurious tick).
//  Vel tick: rising edge of divider[VEL_BIT]. inc_vel -> delay-1 sat DELAY_MIN; dec_vel -> delay+1
//   sat DELAY_MAX; both or neither -> unchanged.
//  FSM: S_WAIT -(step tick & enable)-> S_X -> S_Y -> S_REPORT -> S_WAIT; ticks outside S_WAIT are dropped.
//  S_X: nx = x + vx computed signed in POS_W+2 bits. nx > X_MAX -> x=X_MAX, vx=-|vx|; hit_x.
//   nx < X_MIN -> x=X_MIN, vx=+|vx|; hit_x. Equal to a limit is NOT a hit. Else x=nx.
//  S_Y: same on y/vy/Y limits, sets hit_y.
//  S_REPORT: hit_x&hit_y -> go, number unchanged; hit_x only -> pong, number+1;
//   hit_y only -> ping, number-1 (wraps 0->7); any hit -> sound_stb=1, mute=0, mute count=SOUND_LEN.
//   No hit -> code_sound holds, sound_stb=0. Hit flags clear on leaving S_REPORT.
//  Latency from step tick (cycle T): x_pos T+1, y_pos T+2, number/code_sound/sound_stb T+3.
//  mute: count decrements on each step tick while mute=0; reaches 0 -> mute=1. New hit reloads.
//  enable=0: FSM held in S_WAIT, outputs hold; vel ticks still adjust delay.
//  vx or vy = 0 is legal: axis never moves, never hits.
// STRUCTURE
//  bounce_pkg: sound codes (SND_STOP/PONG/PING/GO), state enum, limit helper functions.
//  Sub-module tick_gen (divider bit select + synchronous rising-edge strobe, reload on sel change),
//   instanced twice: step tick (sel=delay) and vel tick (sel=VEL_BIT).
// TESTING (bench overrides DIV_W/DELAY_INIT small, e.g. DELAY_INIT=2, for speed)
//  Reset with X_INIT=100,Y_INIT=100,vx=1,vy=2; 3 ticks -> x=103,y=106, no sound_stb, mute=1.
//  X_INIT=619,vx=1 -> tick: x=620 (=X_MAX, no hit); next tick: x=620 clamped, vx=-1, pong, number=1.
//  X_INIT=0,Y_INIT=0,vx=-1,vy=-2 -> x=0,y=0, vx=+1,vy=+2, code_sound=go, number=0, single sound_stb.
//  y hit at number=0 -> number=7, ping; then SOUND_LEN=4 ticks without hit -> mute returns 1.
//  Hold inc_vel for 20 vel ticks from 18 -> delay=10 sat; dec_vel+inc_vel together -> unchanged.
//  clr asserted in S_Y mid-step -> next cycle all reset values; enable=0 for 10 ticks -> positions frozen.

Source files
------------

// File: rtl/bounce_pkg.sv
// Shared definitions for the bouncing-sprite motion engine.
//   - sound codes reported on code_sound
//   - FSM state encodings (plain 2-bit constants so older tools can read them)
//   - helpers that turn screen/object/margin sizes into position limits
package bounce_pkg;

    localparam logic [1:0] SND_STOP = 2'b00;
    localparam logic [1:0] SND_PONG = 2'b01;
    localparam logic [1:0] SND_PING = 2'b10;
    localparam logic [1:0] SND_GO   = 2'b11;

    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_X      = 2'd1;
    localparam logic [1:0] S_Y      = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    // Smallest legal top-left coordinate on an axis.
    function automatic int lim_min(input int border);
        return border;
    endfunction

    // Largest legal top-left coordinate on an axis: the object must fit entirely.
    function automatic int lim_max(input int res, input int obj, input int border);
        return res - obj - border;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// One-cycle strobe on the rising edge of a selectable divider bit.
// Ports:
//   clk, clr  - clock and synchronous active-high reset
//   divider   - free-running counter shared with the rest of the block
//   sel       - index of the divider bit to watch
//   tick      - high for one cycle when divider[sel] goes 0 -> 1
// When sel changes, the registered copy is reloaded from the newly selected bit
// and the tick is suppressed for that cycle, so switching bits never fakes an edge.
module tick_gen #(
    parameter int DIV_W = 32,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [DIV_W-1:0] divider,
    input  logic [SEL_W-1:0] sel,
    output logic             tick
);

    logic             cur;
    logic             bit_q;
    logic [SEL_W-1:0] sel_q;

    assign cur  = divider[sel];
    assign tick = (sel == sel_q) && cur && !bit_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            bit_q <= 1'b0;
            sel_q <= sel;
        end else begin
            bit_q <= cur;
            sel_q <= sel;
        end
    end

endmodule

// File: rtl/bounce_motion.sv
// Motion engine for the screen-saver sprite: moves a OBJ_W x OBJ_H object inside
// an H_RES x V_RES area, reflects it off the borders and reports hits as a sound
// code plus a digit change.
// Ports:
//   clk, clr        - clock and synchronous active-high reset
//   enable          - 1 animates; 0 freezes the sprite (divider and speed control keep running)
//   inc_vel/dec_vel - level requests to speed up / slow down, sampled on each vel tick
//   x_pos, y_pos    - object top-left corner
//   number          - displayed digit (mod 8)
//   code_sound      - last sound code, sound_stb pulses for one cycle when a hit updates it
//   mute            - 1 = silence; drops for SOUND_LEN step ticks after a hit
//   dbg_state       - FSM state, dbg_delay - current step divider bit,
//   dbg_step_tick / dbg_vel_tick - internal strobes
// A step runs S_WAIT -> S_X -> S_Y -> S_REPORT; step ticks arriving outside S_WAIT are dropped.
module bounce_motion
    import bounce_pkg::*;
#(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int OBJ_W      = 20,
    parameter int OBJ_H      = 23,
    parameter int BORDER     = 0,
    parameter int POS_W      = 10,
    parameter int VEL_W      = 4,
    parameter int VX_INIT    = 1,
    parameter int VY_INIT    = 2,
    parameter int X_INIT     = 100,
    parameter int Y_INIT     = 100,
    parameter int DIV_W      = 32,
    parameter int DELAY_INIT = 18,
    parameter int DELAY_MIN  = 10,
    parameter int DELAY_MAX  = 26,
    parameter int VEL_BIT    = 23,
    parameter int SOUND_LEN  = 4,
    localparam int DLY_W     = $clog2(DIV_W)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic             inc_vel,
    input  logic             dec_vel,
    output logic [POS_W-1:0] x_pos,
    output logic [POS_W-1:0] y_pos,
    output logic [2:0]       number,
    output logic [1:0]       code_sound,
    output logic             sound_stb,
    output logic             mute,
    output logic [1:0]       dbg_state,
    output logic [DLY_W-1:0] dbg_delay,
    output logic             dbg_step_tick,
    output logic             dbg_vel_tick
);

    localparam int SW    = POS_W + 2;
    localparam int CNT_W = $clog2(SOUND_LEN + 1);

    localparam logic signed [SW-1:0] X_MIN_S = SW'(lim_min(BORDER));
    localparam logic signed [SW-1:0] X_MAX_S = SW'(lim_max(H_RES, OBJ_W, BORDER));
    localparam logic signed [SW-1:0] Y_MIN_S = SW'(lim_min(BORDER));
    localparam logic signed [SW-1:0] Y_MAX_S = SW'(lim_max(V_RES, OBJ_H, BORDER));

    localparam logic [DLY_W-1:0] D_INIT  = DLY_W'(DELAY_INIT);
    localparam logic [DLY_W-1:0] D_MIN   = DLY_W'(DELAY_MIN);
    localparam logic [DLY_W-1:0] D_MAX   = DLY_W'(DELAY_MAX);
    localparam logic [DLY_W-1:0] VEL_SEL = DLY_W'(VEL_BIT);

    logic [DIV_W-1:0]        divider;
    logic [DLY_W-1:0]        delay;
    logic                    step_tick;
    logic                    vel_tick;
    logic [1:0]              state;
    logic signed [VEL_W-1:0] vx, vy;
    logic signed [VEL_W-1:0] vx_neg, vx_pos, vy_neg, vy_pos;
    logic signed [SW-1:0]    nx, ny;
    logic                    hit_x, hit_y;
    logic                    report_hit;
    logic [CNT_W-1:0]        mute_cnt;

    tick_gen #(.DIV_W(DIV_W), .SEL_W(DLY_W)) u_step_tick (
        .clk     (clk),
        .clr     (clr),
        .divider (divider),
        .sel     (delay),
        .tick    (step_tick)
    );

    tick_gen #(.DIV_W(DIV_W), .SEL_W(DLY_W)) u_vel_tick (
        .clk     (clk),
        .clr     (clr),
        .divider (divider),
        .sel     (VEL_SEL),
        .tick    (vel_tick)
    );

    // Next positions in two extra signed bits so overshoot past either border is visible.
    assign nx = $signed({2'b00, x_pos}) + SW'(vx);
    assign ny = $signed({2'b00, y_pos}) + SW'(vy);

    // Reflection forces the sign away from the wall rather than flipping it,
    // so a clamped object can never be pushed back into the same border.
    assign vx_neg = vx[VEL_W-1] ? vx : -vx;
    assign vx_pos = vx[VEL_W-1] ? -vx : vx;
    assign vy_neg = vy[VEL_W-1] ? vy : -vy;
    assign vy_pos = vy[VEL_W-1] ? -vy : vy;

    assign report_hit = (state == S_REPORT) && (hit_x || hit_y);

    assign dbg_state     = state;
    assign dbg_delay     = delay;
    assign dbg_step_tick = step_tick;
    assign dbg_vel_tick  = vel_tick;

    // Divider and saturating speed control.
    always_ff @(posedge clk) begin
        if (clr) begin
            divider <= '0;
            delay   <= D_INIT;
        end else begin
            divider <= divider + 1'b1;
            if (vel_tick) begin
                if (inc_vel && !dec_vel && delay > D_MIN) begin
                    delay <= delay - 1'b1;
                end else if (dec_vel && !inc_vel && delay < D_MAX) begin
                    delay <= delay + 1'b1;
                end
            end
        end
    end

    // Step FSM: one axis per cycle, then report.
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= S_WAIT;
            x_pos      <= POS_W'(X_INIT);
            y_pos      <= POS_W'(Y_INIT);
            vx         <= VEL_W'(VX_INIT);
            vy         <= VEL_W'(VY_INIT);
            hit_x      <= 1'b0;
            hit_y      <= 1'b0;
            number     <= 3'd0;
            code_sound <= SND_STOP;
            sound_stb  <= 1'b0;
        end else begin
            sound_stb <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (step_tick && enable) begin
                        state <= S_X;
                    end
                end
                S_X: begin
                    if (nx > X_MAX_S) begin
                        x_pos <= X_MAX_S[POS_W-1:0];
                        vx    <= vx_neg;
                        hit_x <= 1'b1;
                    end else if (nx < X_MIN_S) begin
                        x_pos <= X_MIN_S[POS_W-1:0];
                        vx    <= vx_pos;
                        hit_x <= 1'b1;
                    end else begin
                        x_pos <= nx[POS_W-1:0];
                    end
                    state <= S_Y;
                end
                S_Y: begin
                    if (ny > Y_MAX_S) begin
                        y_pos <= Y_MAX_S[POS_W-1:0];
                        vy    <= vy_neg;
                        hit_y <= 1'b1;
                    end else if (ny < Y_MIN_S) begin
                        y_pos <= Y_MIN_S[POS_W-1:0];
                        vy    <= vy_pos;
                        hit_y <= 1'b1;
                    end else begin
                        y_pos <= ny[POS_W-1:0];
                    end
                    state <= S_REPORT;
                end
                S_REPORT: begin
                    if (hit_x && hit_y) begin
                        code_sound <= SND_GO;
                    end else if (hit_x) begin
                        code_sound <= SND_PONG;
                        number     <= number + 3'd1;
                    end else if (hit_y) begin
                        code_sound <= SND_PING;
                        number     <= number - 3'd1;
                    end
                    sound_stb <= hit_x || hit_y;
                    hit_x     <= 1'b0;
                    hit_y     <= 1'b0;
                    state     <= S_WAIT;
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    // Mute timer counts step ticks (even while frozen); a fresh hit reloads it.
    always_ff @(posedge clk) begin
        if (clr) begin
            mute     <= 1'b1;
            mute_cnt <= '0;
        end else if (report_hit) begin
            mute     <= 1'b0;
            mute_cnt <= CNT_W'(SOUND_LEN);
        end else if (step_tick && !mute) begin
            if (mute_cnt <= CNT_W'(1)) begin
                mute_cnt <= '0;
                mute     <= 1'b1;
            end else begin
                mute_cnt <= mute_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bounce_motion.sv
// Bench for bounce_motion: four instances with different start conditions run in
// lockstep on shared clock/controls. A reference model predicts each step and pushes
// the packed expectation {x, y, number, code, mute, stb pulses} into exp_q; after the
// DUT finishes the step the entries are popped and compared.
module tb_bounce_motion;

    localparam int N          = 4;
    localparam int W          = 28;
    localparam int DIV_W      = 8;
    localparam int DLY_W      = $clog2(DIV_W);
    localparam int DELAY_INIT = 4;
    localparam int DELAY_MIN  = 2;
    localparam int DELAY_MAX  = 6;
    localparam int VEL_BIT    = 7;
    localparam int SOUND_LEN  = 4;
    localparam int X_MAX      = 640 - 20;
    localparam int Y_MAX      = 480 - 23;

    localparam int P_X  [N] = '{100, 619, 0, 100};
    localparam int P_Y  [N] = '{100, 100, 0, 457};
    localparam int P_VX [N] = '{1, 1, -1, 1};
    localparam int P_VY [N] = '{2, 2, -2, 2};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clr, enable, inc_vel, dec_vel;
    always #5 clk = ~clk;

    logic [9:0]       x_pos_w   [N];
    logic [9:0]       y_pos_w   [N];
    logic [2:0]       number_w  [N];
    logic [1:0]       code_w    [N];
    logic             stb_w     [N];
    logic             mute_w    [N];
    logic [1:0]       state_w   [N];
    logic [DLY_W-1:0] delay_w   [N];
    logic             step_w    [N];
    logic             vel_w     [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        bounce_motion #(
            .VX_INIT(P_VX[g]), .VY_INIT(P_VY[g]), .X_INIT(P_X[g]), .Y_INIT(P_Y[g]),
            .DIV_W(DIV_W), .DELAY_INIT(DELAY_INIT), .DELAY_MIN(DELAY_MIN),
            .DELAY_MAX(DELAY_MAX), .VEL_BIT(VEL_BIT), .SOUND_LEN(SOUND_LEN)
        ) u_dut (
            .clk           (clk),
            .clr           (clr),
            .enable        (enable),
            .inc_vel       (inc_vel),
            .dec_vel       (dec_vel),
            .x_pos         (x_pos_w[g]),
            .y_pos         (y_pos_w[g]),
            .number        (number_w[g]),
            .code_sound    (code_w[g]),
            .sound_stb     (stb_w[g]),
            .mute          (mute_w[g]),
            .dbg_state     (state_w[g]),
            .dbg_delay     (delay_w[g]),
            .dbg_step_tick (step_w[g]),
            .dbg_vel_tick  (vel_w[g])
        );
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_err    = 0;
    logic [W-1:0] exp_q[$];

    int mx[N], my[N], mvx[N], mvy[N], mnum[N], mcode[N], mmute[N], mcnt[N];
    int mdelay;
    int stb_cnt[N];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = P_X[i];  my[i] = P_Y[i];
            mvx[i] = P_VX[i]; mvy[i] = P_VY[i];
            mnum[i] = 0; mcode[i] = 0; mmute[i] = 1; mcnt[i] = 0;
        end
        mdelay = DELAY_INIT;
    endtask

    function automatic logic [W-1:0] pack(input int i, input int stb);
        return {10'(mx[i]), 10'(my[i]), 3'(mnum[i]), 2'(mcode[i]), 1'(mmute[i]), 2'(stb)};
    endfunction

    task automatic model_step(input int i, input bit en);
        int nx, ny;
        bit hx, hy;
        hx = 0; hy = 0;
        if (mmute[i] == 0) begin
            mcnt[i]--;
            if (mcnt[i] == 0) mmute[i] = 1;
        end
        if (en) begin
            nx = mx[i] + mvx[i];
            ny = my[i] + mvy[i];
            if (nx > X_MAX) begin mx[i] = X_MAX; mvx[i] = -((mvx[i] < 0) ? -mvx[i] : mvx[i]); hx = 1; end
            else if (nx < 0) begin mx[i] = 0; mvx[i] = (mvx[i] < 0) ? -mvx[i] : mvx[i]; hx = 1; end
            else mx[i] = nx;
            if (ny > Y_MAX) begin my[i] = Y_MAX; mvy[i] = -((mvy[i] < 0) ? -mvy[i] : mvy[i]); hy = 1; end
            else if (ny < 0) begin my[i] = 0; mvy[i] = (mvy[i] < 0) ? -mvy[i] : mvy[i]; hy = 1; end
            else my[i] = ny;
        end
        if (hx && hy) mcode[i] = 3;
        else if (hx) begin mcode[i] = 1; mnum[i] = (mnum[i] + 1) % 8; end
        else if (hy) begin mcode[i] = 2; mnum[i] = (mnum[i] + 7) % 8; end
        if (hx || hy) begin mmute[i] = 0; mcnt[i] = SOUND_LEN; end
        exp_q.push_back(pack(i, (hx || hy) ? 1 : 0));
    endtask

    task automatic compare_all(input string tag);
        logic [W-1:0] exp, act;
        for (int i = 0; i < N; i++) begin
            if (exp_q.size() == 0) begin
                check($sformatf("%s_dut%0d_empty", tag, i), 0, 1);
            end else begin
                exp = exp_q.pop_front();
                act = {x_pos_w[i], y_pos_w[i], number_w[i], code_w[i], mute_w[i], 2'(stb_cnt[i])};
                check($sformatf("%s_dut%0d", tag, i), 32'(act), 32'(exp));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_step();
        bit found;
        found = 0;
        for (int i = 0; i < N; i++) stb_cnt[i] = 0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            if (step_w[0]) found = 1;
        end
        if (!found) check("step_timeout", 0, 1);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) stb_cnt[i] += int'(stb_w[i]);
        end
    endtask

    task automatic do_step(input bit en, input string tag);
        for (int i = 0; i < N; i++) model_step(i, en);
        wait_step();
        compare_all(tag);
    endtask

    task automatic wait_vel();
        bit found;
        found = 0;
        for (int c = 0; c < 600 && !found; c++) begin
            @(negedge clk);
            if (vel_w[0]) found = 1;
        end
        if (!found) check("vel_timeout", 0, 1);
        if (inc_vel && !dec_vel && mdelay > DELAY_MIN) mdelay--;
        else if (dec_vel && !inc_vel && mdelay < DELAY_MAX) mdelay++;
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < N; i++) begin
            stb_cnt[i] = int'(stb_w[i]);
            exp_q.push_back(pack(i, 0));
        end
        compare_all(tag);
        check({tag, "_state"}, 32'(state_w[0]), 0);
        check({tag, "_delay"}, 32'(delay_w[0]), DELAY_INIT);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        clr = 1'b1; enable = 1'b0; inc_vel = 1'b0; dec_vel = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        clr = 1'b0;
        check_reset("reset");

        // Free motion, clamp at limit, corner, y hit and mute recovery.
        enable = 1'b1;
        for (int s = 1; s <= 6; s++) do_step(1'b1, $sformatf("step%0d", s));

        // Frozen: positions hold, mute timer still runs.
        enable = 1'b0;
        for (int s = 1; s <= 10; s++) do_step(1'b0, $sformatf("frozen%0d", s));

        // Reset while the step is between the x and y updates.
        enable = 1'b1;
        begin
            bit got_y;
            got_y = 0;
            wait_step();
            // wait_step consumed the tick; catch the next one mid-flight
            for (int c = 0; c < 400 && !got_y; c++) begin
                @(negedge clk);
                if (state_w[0] == 2'd2) got_y = 1;
            end
            if (!got_y) check("sy_timeout", 0, 1);
            exp_q.delete();
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            model_reset();
            check_reset("midstep_clr");
        end
        do_step(1'b1, "after_clr");

        // Speed control with the sprite frozen.
        enable  = 1'b0;
        inc_vel = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wait_vel();
            check($sformatf("vel_inc%0d", k), 32'(delay_w[0]), 32'(mdelay));
        end
        dec_vel = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_vel();
            check($sformatf("vel_both%0d", k), 32'(delay_w[0]), 32'(mdelay));
        end
        inc_vel = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wait_vel();
            check($sformatf("vel_dec%0d", k), 32'(delay_w[0]), 32'(mdelay));
        end
        dec_vel = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
